// File: rtl/exmem_pipe_reg_if.sv
// EX/MEM pipeline register bus.
// Groups the EX-side inputs (hazard controls, valid, control word and payload) and the
// registered MEM-side outputs (payload, control word and pre-decoded strobes) in one bundle.
//   master : EX/MEM driver side. Drives stall, flush, in_valid and payload. Observes outputs.
//   slave  : the pipeline register itself.
// When EXMEM_PERF_EN is defined, the bundle also carries the stall_count and flush_count
// performance counters.
interface exmem_pipe_reg_if #(
  parameter int unsigned CTRL_W = 17,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) ();
  // EX side
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [CTRL_W-1:0] control_signals;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [REG_AW-1:0] rd_addr;
  logic [DATA_W-1:0] pc_in;

  // MEM side
  logic              valid_out;
  logic [CTRL_W-1:0] control_signals_out;
  logic [DATA_W-1:0] alu_result_out;
  logic [DATA_W-1:0] store_data_out;
  logic [REG_AW-1:0] rd_addr_out;
  logic [DATA_W-1:0] pc_out;
  logic [1:0]        mem_size_reg;
  logic              mem_rw_reg;
  logic              mem_se_reg;
  logic              mem_enable_reg;
  logic              rf_enable_reg;
  logic              load_instr_reg;
`ifdef EXMEM_PERF_EN
  logic [31:0]       stall_count;
  logic [31:0]       flush_count;
`endif

  modport master (
    output stall, flush, in_valid, control_signals, alu_result, store_data, rd_addr, pc_in,
    input  valid_out, control_signals_out, alu_result_out, store_data_out, rd_addr_out, pc_out,
    input  mem_size_reg, mem_rw_reg, mem_se_reg, mem_enable_reg, rf_enable_reg, load_instr_reg
`ifdef EXMEM_PERF_EN
    ,
    input  stall_count, flush_count
`endif
  );

  modport slave (
    input  stall, flush, in_valid, control_signals, alu_result, store_data, rd_addr, pc_in,
    output valid_out, control_signals_out, alu_result_out, store_data_out, rd_addr_out, pc_out,
    output mem_size_reg, mem_rw_reg, mem_se_reg, mem_enable_reg, rf_enable_reg, load_instr_reg
`ifdef EXMEM_PERF_EN
    ,
    output stall_count, flush_count
`endif
  );
endinterface

// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register.
// This register captures the EX results: ALU result, store data, destination register, PC and
// the control word. It exposes the memory and writeback control fields as strobes for the
// MEM stage. It also tracks valid and supports stall (hold) and flush (bubble).
// Each edge applies the first matching case in this order: reset, flush, stall, load.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset. Clears every output.
//   pipe    : exmem_pipe_reg_if.slave bundle (EX inputs, MEM outputs)
// Optional feature (macro EXMEM_PERF_EN): saturating 32-bit stall and flush event counters.
// If the macro is undefined, no counter logic is built.
module exmem_pipe_reg #(
  parameter int unsigned CTRL_W = 17,  // must be >= 11
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  exmem_pipe_reg_if.slave      pipe
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d,  ctrl_q;
  logic [DATA_W-1:0] alu_d,   alu_q;
  logic [DATA_W-1:0] sdata_d, sdata_q;
  logic [REG_AW-1:0] rd_d,    rd_q;
  logic [DATA_W-1:0] pc_d,    pc_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    alu_d   = alu_q;
    sdata_d = sdata_q;
    rd_d    = rd_q;
    pc_d    = pc_q;
    if (pipe.flush) begin
      // A bubble kills the control word but leaves the payload untouched.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!pipe.stall) begin
      valid_d = pipe.in_valid;
      ctrl_d  = pipe.in_valid ? pipe.control_signals : '0;
      alu_d   = pipe.alu_result;
      sdata_d = pipe.store_data;
      rd_d    = pipe.rd_addr;
      pc_d    = pipe.pc_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      alu_q   <= '0;
      sdata_q <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      alu_q   <= alu_d;
      sdata_q <= sdata_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
    end
  end

  assign pipe.valid_out           = valid_q;
  assign pipe.control_signals_out = ctrl_q;
  assign pipe.alu_result_out      = alu_q;
  assign pipe.store_data_out      = sdata_q;
  assign pipe.rd_addr_out         = rd_q;
  assign pipe.pc_out              = pc_q;

  // The strobes are fields of the registered control word. They cannot disagree with it.
  assign pipe.mem_size_reg   = ctrl_q[6:5];
  assign pipe.mem_rw_reg     = ctrl_q[4];
  assign pipe.mem_se_reg     = ctrl_q[3];
  assign pipe.mem_enable_reg = ctrl_q[0];
  assign pipe.rf_enable_reg  = ctrl_q[9];
  assign pipe.load_instr_reg = ctrl_q[10];

`ifdef EXMEM_PERF_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pipe.flush) begin
      if (flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (pipe.stall) begin
      if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pipe.stall_count = stall_cnt_q;
  assign pipe.flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Self-checking bench for exmem_pipe_reg.
// A behavioural model of the MEM-side state is updated at every rising edge from the documented
// rules and compared against the DUT outputs shortly after the edge.
module tb_exmem_pipe_reg;
  localparam int unsigned CW = 17;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned VW = 1 + CW + 3 * DW + AW + 7;

  logic clk;
  logic reset_n;

  exmem_pipe_reg_if #(.CTRL_W(CW), .DATA_W(DW), .REG_AW(AW)) bus ();

  exmem_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .REG_AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pipe    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // Reference model of what the MEM stage should hold
  logic          m_valid;
  logic [CW-1:0] m_ctrl;
  logic [DW-1:0] m_alu, m_sd, m_pc;
  logic [AW-1:0] m_rd;
`ifdef EXMEM_PERF_EN
  logic [31:0]   m_stall_cnt, m_flush_cnt;
`endif

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, m_ctrl, m_alu, m_sd, m_rd, m_pc,
            m_ctrl[6:5], m_ctrl[4], m_ctrl[3], m_ctrl[0], m_ctrl[9], m_ctrl[10]};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.valid_out, bus.control_signals_out, bus.alu_result_out, bus.store_data_out,
            bus.rd_addr_out, bus.pc_out, bus.mem_size_reg, bus.mem_rw_reg, bus.mem_se_reg,
            bus.mem_enable_reg, bus.rf_enable_reg, bus.load_instr_reg};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_ctrl  = '0;
    m_alu   = '0;
    m_sd    = '0;
    m_rd    = '0;
    m_pc    = '0;
`ifdef EXMEM_PERF_EN
    m_stall_cnt = '0;
    m_flush_cnt = '0;
`endif
  endtask

  // One clock edge with reset_n high, described in terms of the stage's behaviour
  task automatic model_edge();
    if (bus.flush) begin
      m_valid = 1'b0;
      m_ctrl  = '0;
    end else if (!bus.stall) begin
      m_valid = bus.in_valid;
      m_ctrl  = bus.in_valid ? bus.control_signals : '0;
      m_alu   = bus.alu_result;
      m_sd    = bus.store_data;
      m_rd    = bus.rd_addr;
      m_pc    = bus.pc_in;
    end
`ifdef EXMEM_PERF_EN
    if (bus.flush && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
    if (bus.stall && !bus.flush && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
`endif
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] a,
                       input logic [DW-1:0] s, input logic [AW-1:0] r, input logic [DW-1:0] p,
                       input logic st, input logic fl);
    bus.in_valid        = v;
    bus.control_signals = c;
    bus.alu_result      = a;
    bus.store_data      = s;
    bus.rd_addr         = r;
    bus.pc_in           = p;
    bus.stall           = st;
    bus.flush           = fl;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 17'h1FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, 32'hFFFF_FFFF, 1'b0, 1'b0);
    model_reset();
    #3;
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_initial: got %h want %h", obs_vec(), exp_vec());
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_held_over_edge: got %h want %h", obs_vec(), exp_vec());
    end
`ifdef EXMEM_PERF_EN
    n_cmp++;
    if (bus.stall_count !== 32'd0 || bus.flush_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %h/%h want 0/0", bus.stall_count, bus.flush_count);
    end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_load();
    drive(1'b1, 17'h0061D, 32'h0000_1004, 32'hCAFE_0001, 5'd8, 32'h0000_0400, 1'b0, 1'b0);
    step();
    n_cmp++;
    if ({bus.valid_out, bus.mem_size_reg, bus.mem_rw_reg, bus.mem_se_reg, bus.mem_enable_reg,
         bus.rf_enable_reg, bus.load_instr_reg} !== 8'b1_00_11111) begin
      n_fail++;
      $display("FAIL load_strobes: got %b%b%b%b%b%b%b want 10011111", bus.valid_out,
               bus.mem_size_reg, bus.mem_rw_reg, bus.mem_se_reg, bus.mem_enable_reg,
               bus.rf_enable_reg, bus.load_instr_reg);
    end
    n_cmp++;
    if (bus.alu_result_out !== 32'h0000_1004 || bus.rd_addr_out !== 5'd8) begin
      n_fail++;
      $display("FAIL load_payload: got alu %h rd %0d want 00001004 rd 8", bus.alu_result_out,
               bus.rd_addr_out);
    end
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL load_full: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] a_alu;
    logic [DW-1:0] a_pc;
    // Short reset so the counters start from zero
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    model_reset();
    a_alu = $urandom;
    a_pc  = $urandom;
    drive(1'b1, 17'h00611, a_alu, $urandom, 5'd3, a_pc, 1'b0, 1'b0);
    step();
    drive(1'b1, 17'h0020C, ~a_alu, $urandom, 5'd21, ~a_pc, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (bus.alu_result_out !== a_alu || bus.pc_out !== a_pc ||
          bus.control_signals_out !== 17'h00611 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
`ifdef EXMEM_PERF_EN
    n_cmp++;
    if (bus.stall_count !== 32'd3) begin
      n_fail++;
      $display("FAIL stall_count: got %0d want 3", bus.stall_count);
    end
`endif
  endtask

  task automatic test_flush();
    logic [DW-1:0] prev_pc;
    prev_pc = m_pc;
    drive(1'b1, 17'h1FFFF, $urandom, $urandom, 5'd7, ~prev_pc, 1'b1, 1'b1);
    step();
    n_cmp++;
    if (bus.valid_out !== 1'b0 || bus.control_signals_out !== '0 ||
        bus.mem_enable_reg !== 1'b0 || bus.pc_out !== prev_pc) begin
      n_fail++;
      $display("FAIL flush_bubble: got v%b c%h en%b pc%h want v0 c0 en0 pc%h", bus.valid_out,
               bus.control_signals_out, bus.mem_enable_reg, bus.pc_out, prev_pc);
    end
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL flush_full: got %h want %h", obs_vec(), exp_vec());
    end
`ifdef EXMEM_PERF_EN
    n_cmp++;
    if (bus.flush_count !== 32'd1 || bus.stall_count !== 32'd3) begin
      n_fail++;
      $display("FAIL flush_counts: got f%0d s%0d want f1 s3", bus.flush_count, bus.stall_count);
    end
`endif
  endtask

  task automatic test_invalid();
    logic [DW-1:0] a;
    a = $urandom;
    drive(1'b0, 17'h1FFFF, a, $urandom, 5'd31, $urandom, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (bus.control_signals_out !== '0 || bus.valid_out !== 1'b0 || bus.alu_result_out !== a) begin
      n_fail++;
      $display("FAIL invalid_input: got v%b c%h alu%h want v0 c0 alu%h", bus.valid_out,
               bus.control_signals_out, bus.alu_result_out, a);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 17'h0063F, 32'h1234_5678, 32'h9ABC_DEF0, 5'd5, 32'h0000_0040, 1'b0, 1'b0);
    step();
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_flush: got %h want %h", obs_vec(), exp_vec());
    end
    @(posedge clk);
    #2;
    drive(1'b1, 17'h00219, 32'h0000_2000, 32'h0000_00AA, 5'd9, 32'h0000_0100, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();
    n_cmp++;
    if (obs_vec() !== exp_vec() || bus.pc_out !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL first_load_after_reset: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), CW'($urandom), $urandom, $urandom, AW'($urandom),
            $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0));
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (bus.valid_out === 1'b0 &&
          (bus.mem_enable_reg | bus.mem_rw_reg | bus.rf_enable_reg) !== 1'b0) begin
        n_fail++;
        $display("FAIL bubble_strobes[%0d]: got en%b rw%b rf%b want 000", i,
                 bus.mem_enable_reg, bus.mem_rw_reg, bus.rf_enable_reg);
      end
`ifdef EXMEM_PERF_EN
      n_cmp++;
      if (bus.stall_count !== m_stall_cnt || bus.flush_count !== m_flush_cnt) begin
        n_fail++;
        $display("FAIL random_counts[%0d]: got s%0d f%0d want s%0d f%0d", i, bus.stall_count,
                 bus.flush_count, m_stall_cnt, m_flush_cnt);
      end
`endif
    end
  endtask

`ifdef EXMEM_PERF_EN
  task automatic test_saturation();
    logic [31:0] f_before;
    f_before = m_flush_cnt;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_stall_cnt = 32'hFFFF_FFFE;
    drive(1'b1, 17'h00001, $urandom, $urandom, 5'd1, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (bus.stall_count !== 32'hFFFF_FFFF || bus.flush_count !== f_before) begin
      n_fail++;
      $display("FAIL stall_saturation: got s%h f%h want sFFFFFFFF f%h", bus.stall_count,
               bus.flush_count, f_before);
    end
    bus.stall = 1'b0;
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_invalid();
    test_reset_mid_stall();
    test_random();
`ifdef EXMEM_PERF_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
